// File: rtl/cache_drain_engine_pkg.sv
// Shared definitions for the MEM-stage cache drain engine: state encoding,
// the drain opcode and the default cache geometry.
package cache_drain_engine_pkg;

  localparam logic [6:0] DRAIN_OPCODE = 7'h7f;

  localparam int unsigned DEF_NUM_LINES = 4;
  localparam int unsigned DEF_LINE_W    = 128;
  localparam int unsigned DEF_TAG_W     = 26;

  typedef logic [DEF_LINE_W-1:0] cache_line_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_UPDATE = 3'd4,
    ST_DONE   = 3'd5
  } drain_state_t;

  // A single-line cache still needs a 1-bit index so ports never collapse.
  function automatic int unsigned idx_width(input int unsigned lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/drain_addr_gen.sv
// Line index walker with terminal-count flag and the registered write-back
// address {tag, index, zero byte offset}.
module drain_addr_gen #(
  parameter  int unsigned NUM_LINES = 4,
  parameter  int unsigned TAG_W     = 26,
  parameter  int unsigned IDX_W     = 2,
  parameter  int unsigned OFF_W     = 4,
  localparam int unsigned ADDR_W    = TAG_W + IDX_W + OFF_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              last_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Next index and next captured address.
  always_comb begin
    idx_d  = idx_q;
    addr_d = addr_q;
    if (clr_i) begin
      idx_d = {IDX_W{1'b0}};
    end else if (inc_i) begin
      idx_d = idx_q + IDX_W'(1'b1);
    end else begin
      idx_d = idx_q;
    end
    if (load_i) begin
      addr_d = {tag_i, idx_q, {OFF_W{1'b0}}};
    end else begin
      addr_d = addr_q;
    end
  end

  // Index and address registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= {IDX_W{1'b0}};
      addr_q <= {ADDR_W{1'b0}};
    end else begin
      idx_q  <= idx_d;
      addr_q <= addr_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == LAST_IDX);
  assign addr_o = addr_q;

endmodule

// File: rtl/cache_drain_engine.sv
// Drain/flush controller: walks every cache line, writes valid+dirty lines
// back to memory and optionally invalidates, stalling the pipeline meanwhile.
module cache_drain_engine
  import cache_drain_engine_pkg::*;
#(
  parameter  int unsigned NUM_LINES = DEF_NUM_LINES,
  parameter  int unsigned LINE_W    = DEF_LINE_W,
  parameter  int unsigned TAG_W     = DEF_TAG_W,
  localparam int unsigned IDX_W     = idx_width(NUM_LINES),
  localparam int unsigned OFF_W     = $clog2(LINE_W / 8),
  localparam int unsigned ADDR_W    = TAG_W + IDX_W + OFF_W,
  localparam int unsigned CNT_W     = $clog2(NUM_LINES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              invalidate,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [IDX_W-1:0]  line_idx,
  output logic              tag_rd_en,
  input  logic              tag_rd_valid,
  input  logic              tag_rd_dirty,
  input  logic [TAG_W-1:0]  tag_rd_tag,
  input  logic [LINE_W-1:0] data_rd_line,
  output logic              line_wr_en,
  output logic              line_wr_valid,
  output logic              line_wr_dirty,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  lines_written
);

  drain_state_t      state_q, state_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] data_q, data_d;

  logic idx_clr_s, idx_inc_s, addr_load_s, idx_last_s;

  logic busy_q, done_q, rd_en_q, wr_en_q, wr_valid_q, req_q;

  drain_addr_gen #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W),
    .IDX_W     (IDX_W),
    .OFF_W     (OFF_W)
  ) u_drain_addr_gen (
    .clk_i  (clock),
    .rst_ni (reset),
    .clr_i  (idx_clr_s),
    .inc_i  (idx_inc_s),
    .load_i (addr_load_s),
    .tag_i  (tag_rd_tag),
    .idx_o  (line_idx),
    .last_o (idx_last_s),
    .addr_o (mem_addr)
  );

  // Next-state logic; "advance" either finishes on the last line or steps the index.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    idx_clr_s   = 1'b0;
    idx_inc_s   = 1'b0;
    addr_load_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_READ;
          mode_d    = invalidate;
          cnt_d     = {CNT_W{1'b0}};
          idx_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (tag_rd_valid && tag_rd_dirty) begin
          state_d     = ST_WRITE;
          addr_load_s = 1'b1;
          data_d      = data_rd_line;
        end else if (tag_rd_valid && mode_q) begin
          state_d = ST_UPDATE;
        end else if (idx_last_s) begin
          state_d = ST_DONE;
        end else begin
          idx_inc_s = 1'b1;
          state_d   = ST_READ;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          cnt_d   = cnt_q + CNT_W'(1'b1);
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_UPDATE: begin
        if (idx_last_s) begin
          state_d = ST_DONE;
        end else begin
          idx_inc_s = 1'b1;
          state_d   = ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured mode, write-back counter and line data registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      data_q  <= {LINE_W{1'b0}};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      rd_en_q    <= (state_d == ST_READ);
      wr_en_q    <= (state_d == ST_UPDATE);
      wr_valid_q <= (state_d == ST_UPDATE) && !mode_d;
      req_q      <= (state_d == ST_WRITE);
    end
  end

  assign busy          = busy_q;
  assign stall         = busy_q;
  assign done          = done_q;
  assign tag_rd_en     = rd_en_q;
  assign line_wr_en    = wr_en_q;
  assign line_wr_valid = wr_valid_q;
  assign line_wr_dirty = 1'b0;
  assign mem_req       = req_q;
  assign mem_wdata     = data_q;
  assign lines_written = cnt_q;

endmodule
